// File: rtl/localbus_arbiter.sv
// Two-master round-robin arbiter feeding a registered localbus slave stage (2-cycle latency).
// Optional bus lock is enabled by defining LOCALBUS_ARB_LOCK_EN.
module localbus_arbiter #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic [AWIDTH-1:0] i_m0_addr,
    input  logic [XLEN-1:0]   i_m0_wdata,
    input  logic [2:0]        i_m0_we,
    input  logic              i_m0_lock,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [XLEN-1:0]   o_m0_rdata,
    input  logic              i_m1_req,
    input  logic [AWIDTH-1:0] i_m1_addr,
    input  logic [XLEN-1:0]   i_m1_wdata,
    input  logic [2:0]        i_m1_we,
    input  logic              i_m1_lock,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [XLEN-1:0]   o_m1_rdata,
    output logic [AWIDTH-1:0] o_s_addr,
    output logic [XLEN-1:0]   o_s_qin,
    output logic [2:0]        o_s_we,
    input  logic [XLEN-1:0]   i_s_qout
);

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1} stage_t;

    stage_t            r_state, w_state_nxt;
    logic              r_rr_last;
    logic              r_m0_rvalid, r_m1_rvalid;
    logic [XLEN-1:0]   r_m0_rdata, r_m1_rdata;
    logic [AWIDTH-1:0] r_s_addr;
    logic [XLEN-1:0]   r_s_qin;
    logic [2:0]        r_s_we;
    logic              w_req0, w_req1, w_gnt0, w_gnt1;
    logic              w_lock_hold, w_lock_own;

    // Grants are gated by reset so nothing is accepted while the stage is held clear.
    assign w_req0 = i_m0_req & i_rst_n;
    assign w_req1 = i_m1_req & i_rst_n;

`ifdef LOCALBUS_ARB_LOCK_EN
    logic r_locked, r_lock_own;
    assign w_lock_hold = r_locked && (r_lock_own ? i_m1_lock : i_m0_lock);
    assign w_lock_own  = r_lock_own;
`else
    logic w_unused_lock;
    assign w_unused_lock = i_m0_lock ^ i_m1_lock;
    assign w_lock_hold   = 1'b0;
    assign w_lock_own    = 1'b0;
`endif

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = S_IDLE;
        if (w_lock_hold) begin
            w_gnt0 = !w_lock_own && w_req0;
            w_gnt1 =  w_lock_own && w_req1;
        end else if (w_req0 && w_req1) begin
            w_gnt0 =  r_rr_last;
            w_gnt1 = !r_rr_last;
        end else begin
            w_gnt0 = w_req0;
            w_gnt1 = w_req1;
        end
        if (w_gnt0)      w_state_nxt = S_ACC0;
        else if (w_gnt1) w_state_nxt = S_ACC1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rr_last   <= 1'b1;
            r_s_addr    <= '0;
            r_s_qin     <= '0;
            r_s_we      <= '0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0 || w_gnt1) r_rr_last <= w_gnt1;
            if (w_gnt0) begin
                r_s_addr <= i_m0_addr;
                r_s_qin  <= i_m0_wdata;
                r_s_we   <= i_m0_we;
            end else if (w_gnt1) begin
                r_s_addr <= i_m1_addr;
                r_s_qin  <= i_m1_wdata;
                r_s_we   <= i_m1_we;
            end else begin
                r_s_we   <= 3'b000;
            end
            // Completion is steered by the stage owner; writes ack without touching rdata.
            r_m0_rvalid <= (r_state == S_ACC0);
            r_m1_rvalid <= (r_state == S_ACC1);
            if (r_state == S_ACC0 && r_s_we == 3'b000) r_m0_rdata <= i_s_qout;
            if (r_state == S_ACC1 && r_s_we == 3'b000) r_m1_rdata <= i_s_qout;
        end
    end

`ifdef LOCALBUS_ARB_LOCK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_locked   <= 1'b0;
            r_lock_own <= 1'b0;
        end else if (w_gnt0 && i_m0_lock) begin
            r_locked   <= 1'b1;
            r_lock_own <= 1'b0;
        end else if (w_gnt1 && i_m1_lock) begin
            r_locked   <= 1'b1;
            r_lock_own <= 1'b1;
        end else if (!w_lock_hold) begin
            r_locked   <= 1'b0;
        end
    end
`endif

    assign o_m0_gnt    = w_gnt0;
    assign o_m1_gnt    = w_gnt1;
    assign o_m0_rvalid = r_m0_rvalid;
    assign o_m1_rvalid = r_m1_rvalid;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;
    assign o_s_addr    = r_s_addr;
    assign o_s_qin     = r_s_qin;
    assign o_s_we      = r_s_we;

endmodule

// File: tb/tb_localbus_arbiter.sv
// Directed bench for localbus_arbiter: per-cycle vector table plus hand sequences
// for single access, write ack and reset mid-flight.
module tb_localbus_arbiter;

`ifdef LOCALBUS_ARB_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [2:0]  m0_we;
    logic        m1_req, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [2:0]  m1_we;
    logic [31:0] s_addr, s_qin, s_qout;
    logic [2:0]  s_we;

    int n_tests = 0;
    int n_fail  = 0;

    localbus_arbiter #(.XLEN(32), .AWIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_we(m0_we),
        .i_m0_lock(m0_lock), .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_we(m1_we),
        .i_m1_lock(m1_lock), .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_s_addr(s_addr), .o_s_qin(s_qin), .o_s_we(s_we), .i_s_qout(s_qout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, req0, req1, lock1;
        logic [2:0] we1;
        logic       eg0, eg1, chk_rv, erv0, erv1;
        logic [2:0] eswe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, a, b, l1, input logic [2:0] w1,
                                input logic g0, g1, c, v0, v1, input logic [2:0] sw);
        vec_t t;
        t.rst_n = r; t.req0 = a; t.req1 = b; t.lock1 = l1; t.we1 = w1;
        t.eg0 = g0; t.eg1 = g1; t.chk_rv = c; t.erv0 = v0; t.erv1 = v1; t.eswe = sw;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m0_lock = 1'b0; m1_lock = 1'b0;
        m0_addr = 32'h100; m0_wdata = 32'h11; m0_we = 3'b000;
        m1_addr = 32'h8;   m1_wdata = 32'h5A; m1_we = 3'b000;
        s_qout = 32'hDEADBEEF;

        // reset (5 rows), tie alternation, idle drain, M1 write, M0 streaming
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,1,0,3'b000, 0,0,1,0,0,3'b000));
        tbl.push_back(mk(1,1,1,0,3'b000, 1,0,1,0,0,3'b000));
        tbl.push_back(mk(1,1,1,0,3'b000, 0,1,1,0,0,3'b000));
        tbl.push_back(mk(1,1,1,0,3'b000, 1,0,1,1,0,3'b000));
        tbl.push_back(mk(1,1,1,0,3'b000, 0,1,1,0,1,3'b000));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,1,0,3'b000));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,0,1,3'b000));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,0,0,3'b000));
        tbl.push_back(mk(1,0,1,0,3'b010, 0,1,1,0,0,3'b000));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,0,0,3'b010));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,0,1,3'b000));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,0,0,3'b000));
        tbl.push_back(mk(1,1,0,0,3'b000, 1,0,1,0,0,3'b000));
        tbl.push_back(mk(1,1,0,0,3'b000, 1,0,1,0,0,3'b000));
        tbl.push_back(mk(1,1,0,0,3'b000, 1,0,1,1,0,3'b000));
        tbl.push_back(mk(1,1,1,0,3'b000, 0,1,1,1,0,3'b000));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,1,0,3'b000));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,0,1,3'b000));
        tbl.push_back(mk(1,0,0,0,3'b000, 0,0,1,0,0,3'b000));
        // lock phase: M0 last winner, then M1 requests with lock while M0 keeps requesting
        tbl.push_back(mk(1,1,0,0,3'b000, 1,0,1,0,0,3'b000));
        tbl.push_back(mk(1,1,1,1,3'b000, 0,1,0,0,0,3'b000));
        tbl.push_back(mk(1,1,1,1,3'b000, !LK,LK,0,0,0,3'b000));
        tbl.push_back(mk(1,1,1,1,3'b000, 0,1,0,0,0,3'b000));
        tbl.push_back(mk(1,1,1,1,3'b000, !LK,LK,0,0,0,3'b000));
        tbl.push_back(mk(1,1,0,1,3'b000, !LK,0,0,0,0,3'b000));
        tbl.push_back(mk(1,1,1,0,3'b000, LK,!LK,0,0,0,3'b000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,3'b000, 0,0,0,0,0,3'b000));

        @(negedge clk);
        chk("rst_rdata0", m0_rdata, 32'h0);
        chk("rst_rdata1", m1_rdata, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_qin",  s_qin,  32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            step();
            rst_n = tbl[i].rst_n; m0_req = tbl[i].req0; m1_req = tbl[i].req1;
            m1_lock = tbl[i].lock1; m1_we = tbl[i].we1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), {31'b0, m0_gnt}, {31'b0, tbl[i].eg0});
            chk($sformatf("v%0d_gnt1", i), {31'b0, m1_gnt}, {31'b0, tbl[i].eg1});
            chk($sformatf("v%0d_s_we", i), {29'b0, s_we}, {29'b0, tbl[i].eswe});
            chk($sformatf("v%0d_onegnt", i), {31'b0, m0_gnt & m1_gnt}, 32'h0);
            if (tbl[i].chk_rv) begin
                chk($sformatf("v%0d_rv0", i), {31'b0, m0_rvalid}, {31'b0, tbl[i].erv0});
                chk($sformatf("v%0d_rv1", i), {31'b0, m1_rvalid}, {31'b0, tbl[i].erv1});
            end
        end

        // M0 read with fixed 2-cycle latency
        step(); m0_req = 1'b1; m0_addr = 32'h100; m0_we = 3'b000; s_qout = 32'hDEADBEEF;
        @(negedge clk); chk("rd_gnt0", {31'b0, m0_gnt}, 32'h1);
        step(); m0_req = 1'b0;
        @(negedge clk);
        chk("rd_s_addr", s_addr, 32'h100);
        chk("rd_s_we", {29'b0, s_we}, 32'h0);
        chk("rd_rv0_early", {31'b0, m0_rvalid}, 32'h0);
        step(); @(negedge clk);
        chk("rd_rv0", {31'b0, m0_rvalid}, 32'h1);
        chk("rd_rdata0", m0_rdata, 32'hDEADBEEF);
        step(); @(negedge clk);
        chk("rd_rv0_pulse", {31'b0, m0_rvalid}, 32'h0);

        // M1 read to seed rdata, then a write that must ack without changing it
        step(); m1_req = 1'b1; m1_we = 3'b000; s_qout = 32'hCAFEF00D;
        step(); m1_req = 1'b0;
        step(); @(negedge clk);
        chk("seed_rdata1", m1_rdata, 32'hCAFEF00D);
        step(); m1_req = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h5A; m1_we = 3'b010; s_qout = 32'h12345678;
        @(negedge clk); chk("wr_gnt1", {31'b0, m1_gnt}, 32'h1);
        step(); m1_req = 1'b0; m1_we = 3'b000;
        @(negedge clk);
        chk("wr_s_we", {29'b0, s_we}, 32'h2);
        chk("wr_s_qin", s_qin, 32'h5A);
        chk("wr_s_addr", s_addr, 32'h8);
        step(); @(negedge clk);
        chk("wr_s_we_off", {29'b0, s_we}, 32'h0);
        chk("wr_rv1", {31'b0, m1_rvalid}, 32'h1);
        chk("wr_rdata1_kept", m1_rdata, 32'hCAFEF00D);

        // reset one cycle after an M0 write grant drops the access
        step(); m0_req = 1'b1; m0_we = 3'b001;
        @(negedge clk); chk("rst_gnt0", {31'b0, m0_gnt}, 32'h1);
        step(); m0_req = 1'b0; m0_we = 3'b000; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_s_we", {29'b0, s_we}, 32'h0);
        chk("rst_mid_s_addr", s_addr, 32'h0);
        step(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d_rv0", k), {31'b0, m0_rvalid}, 32'h0);
            chk($sformatf("rst_after%0d_s_we", k), {29'b0, s_we}, 32'h0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
